// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC control slice: FSM state encoding,
// redirect cause encoding and the sequential fetch step.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT     = 2'd2,
        ST_REDIRECT = 2'd3
    } pc_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_TRAP     = 3'd1,
        CAUSE_JUMP     = 3'd2,
        CAUSE_BRANCH   = 3'd3,
        CAUSE_MISALIGN = 3'd4
    } redirect_cause_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational redirect selector: trap beats jump beats branch.
// With PC_CTRL_MISALIGN_CHK_EN defined, a misaligned jump/branch target becomes a trap redirect.
module pc_redirect_sel
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic            trap,
    input  logic            jump,
    input  logic [31:0]     jump_target,
    input  logic            branch_taken,
    input  logic [31:0]     branch_target,
    output logic            redirect,
    output logic [31:0]     target,
    output redirect_cause_e cause
);

    always_comb begin
        redirect = 1'b0;
        target   = TRAP_VECTOR;
        cause    = CAUSE_NONE;
        if (trap) begin
            redirect = 1'b1;
            target   = TRAP_VECTOR;
            cause    = CAUSE_TRAP;
        end else if (jump) begin
            redirect = 1'b1;
            target   = jump_target;
            cause    = CAUSE_JUMP;
        end else if (branch_taken) begin
            redirect = 1'b1;
            target   = branch_target;
            cause    = CAUSE_BRANCH;
        end
`ifdef PC_CTRL_MISALIGN_CHK_EN
        // Only control-flow targets are checked; the trap vector is trusted.
        if ((cause == CAUSE_JUMP || cause == CAUSE_BRANCH) && is_misaligned(target)) begin
            target = TRAP_VECTOR;
            cause  = CAUSE_MISALIGN;
        end
`endif
    end

endmodule

// File: rtl/pc_ctrl.sv
// PC control FSM: boot sequencing, sequential fetch, stalls, memory waits and redirects.
// Optional misaligned-target trapping is enabled by defining PC_CTRL_MISALIGN_CHK_EN.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned BOOT_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        trap,
    output logic        pc_en,
    output logic [31:0] next_pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        misalign_err,
    output logic [1:0]  state
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    pc_state_e       state_q, state_d;
    logic [3:0]      boot_cnt_q, boot_cnt_d;
    logic            sel_redirect;
    logic [31:0]     sel_target;
    redirect_cause_e sel_cause;

    pc_redirect_sel #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_sel (
        .trap          (trap),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .redirect      (sel_redirect),
        .target        (sel_target),
        .cause         (sel_cause)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    // rst_n also gates the decode so outputs take reset values without waiting for a clock.
    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        pc_en        = 1'b0;
        next_pc      = pc_in;
        fetch_valid  = 1'b0;
        flush        = 1'b0;
        misalign_err = 1'b0;
        if (!rst_n) begin
            next_pc = RESET_VECTOR;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    if (boot_cnt_q == 4'd0) begin
                        pc_en   = 1'b1;
                        next_pc = RESET_VECTOR;
                    end
                    if (boot_cnt_q == BOOT_LAST) begin
                        state_d    = ST_RUN;
                        boot_cnt_d = 4'd0;
                    end else begin
                        boot_cnt_d = boot_cnt_q + 4'd1;
                    end
                end
                ST_RUN, ST_WAIT: begin
                    if (sel_redirect) begin
                        pc_en        = 1'b1;
                        next_pc      = sel_target;
                        flush        = 1'b1;
                        misalign_err = (sel_cause == CAUSE_MISALIGN);
                        state_d      = ST_REDIRECT;
                    end else if (stall) begin
                        state_d = state_q;
                    end else if (!imem_ready) begin
                        state_d = ST_WAIT;
                    end else begin
                        pc_en       = 1'b1;
                        next_pc     = pc_in + PC_STEP;
                        fetch_valid = 1'b1;
                        state_d     = ST_RUN;
                    end
                end
                ST_REDIRECT: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl with default parameters.
// Misalign expectations follow PC_CTRL_MISALIGN_CHK_EN.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        stall;
    logic        imem_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
    logic        pc_en;
    logic [31:0] next_pc;
    logic        fetch_valid;
    logic        flush;
    logic        misalign_err;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    pc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_in         (pc_in),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .pc_en         (pc_en),
        .next_pc       (next_pc),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .misalign_err  (misalign_err),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic [31:0] pc, input logic st, input logic rdy,
                                 input logic tr, input logic jp, input logic [31:0] jt,
                                 input logic br, input logic [31:0] bt);
        @(negedge clk);
        pc_in         = pc;
        stall         = st;
        imem_ready    = rdy;
        trap          = tr;
        jump          = jp;
        jump_target   = jt;
        branch_taken  = br;
        branch_target = bt;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic exp_en, input logic [31:0] exp_pc,
                               input logic exp_fv, input logic exp_fl, input logic exp_mis,
                               input logic [1:0] exp_st);
        n_cmp++;
        assert (pc_en === exp_en) else begin
            n_err++;
            $error("[TB] FAIL %s pc_en observed=%0b expected=%0b", tag, pc_en, exp_en);
        end
        n_cmp++;
        assert (next_pc === exp_pc) else begin
            n_err++;
            $error("[TB] FAIL %s next_pc observed=%h expected=%h", tag, next_pc, exp_pc);
        end
        n_cmp++;
        assert (fetch_valid === exp_fv) else begin
            n_err++;
            $error("[TB] FAIL %s fetch_valid observed=%0b expected=%0b", tag, fetch_valid, exp_fv);
        end
        n_cmp++;
        assert (flush === exp_fl) else begin
            n_err++;
            $error("[TB] FAIL %s flush observed=%0b expected=%0b", tag, flush, exp_fl);
        end
        n_cmp++;
        assert (misalign_err === exp_mis) else begin
            n_err++;
            $error("[TB] FAIL %s misalign_err observed=%0b expected=%0b", tag, misalign_err, exp_mis);
        end
        n_cmp++;
        assert (state === exp_st) else begin
            n_err++;
            $error("[TB] FAIL %s state observed=%0d expected=%0d", tag, state, exp_st);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        pc_in         = 32'h0000_1234;
        stall         = 1'b0;
        imem_ready    = 1'b1;
        trap          = 1'b0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        #1;
        $display("[TB] reset and boot");
        checkOutput("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("boot1", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("boot2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("seq0", 1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 2'd1);
        applyStimulus(32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("seq4", 1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 2'd1);
        applyStimulus(32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("seq8", 1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 2'd1);

        $display("[TB] redirect priority");
        applyStimulus(32'h10, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
        checkOutput("trap_prio", 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 2'd1);
        applyStimulus(32'h100, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
        checkOutput("bubble", 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 2'd3);
        applyStimulus(32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("post_redir", 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 2'd1);

        $display("[TB] stall and wait");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h104, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            checkOutput("stall", 1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 2'd1);
        end
        applyStimulus(32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("nready_run", 1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 2'd1);
        applyStimulus(32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("nready_wait", 1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 2'd2);
        applyStimulus(32'h104, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("wait_stall", 1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 2'd2);
        applyStimulus(32'h104, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("wait_resume", 1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 2'd2);
        applyStimulus(32'h108, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("back_run", 1'b1, 32'h10C, 1'b1, 1'b0, 1'b0, 2'd1);

        $display("[TB] redirect over stall");
        applyStimulus(32'h10C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h200);
        checkOutput("jump_prio", 1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 2'd1);
        applyStimulus(32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("bubble2", 1'b0, 32'h300, 1'b0, 1'b0, 1'b0, 2'd3);
        applyStimulus(32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
        checkOutput("branch", 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 2'd1);
        applyStimulus(32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("bubble3", 1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 2'd3);

        $display("[TB] wrap");
        applyStimulus(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("wrap", 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 2'd1);

        $display("[TB] misaligned jump");
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h42, 1'b0, 32'h0);
`ifdef PC_CTRL_MISALIGN_CHK_EN
        checkOutput("misalign", 1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 2'd1);
`else
        checkOutput("misalign", 1'b1, 32'h42, 1'b0, 1'b1, 1'b0, 2'd1);
`endif
        applyStimulus(32'h42, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("bubble4", 1'b0, 32'h42, 1'b0, 1'b0, 1'b0, 2'd3);

        $display("[TB] async reset mid-WAIT");
        applyStimulus(32'h50, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("to_wait", 1'b0, 32'h50, 1'b0, 1'b0, 1'b0, 2'd1);
        applyStimulus(32'h50, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("in_wait", 1'b0, 32'h50, 1'b0, 1'b0, 1'b0, 2'd2);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);

        @(negedge clk);
        rst_n = 1'b1;
        trap  = 1'b1;
        stall = 1'b1;
        #1;
        checkOutput("reboot1", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        checkOutput("reboot2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("reboot_run", 1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, address loaded into the PC on leaving reset.
REQ-002 Parameter TRAP_VECTOR, 32'h0000_0100, redirect address on trap.
REQ-003 Parameter BOOT_CYCLES, 2, cycles spent in BOOT after reset release (range 1-15).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 pc_in  in  32  current PC from the program-counter register.
REQ-007 stall  in  1  hazard stall; hold PC.
REQ-008 imem_ready  in  1  instruction memory can accept a fetch this cycle.
REQ-009 branch_taken / branch_target  in  1 / 32  resolved taken branch and its target.
REQ-010 jump / jump_target  in  1 / 32  JAL/JALR and its target.
REQ-011 trap  in  1  exception/ecall request.
REQ-012 pc_en  out  1  write enable for the PC register.
REQ-013 next_pc  out  32  value the PC register loads when pc_en=1.
REQ-014 fetch_valid  out  1  instruction at pc_in is being fetched this cycle.
REQ-015 flush  out  1  one-cycle pulse: discard younger pipeline instructions.
REQ-016 misalign_err  out  1  one-cycle pulse: redirect target bits[1:0] != 0.
REQ-017 state  out  2  current FSM state (debug).

Function
REQ-018 FSM states SHALL be BOOT=0, RUN=1, WAIT=2, REDIRECT=3; outputs are combinational decode of registered state plus inputs.
REQ-019 BOOT: first cycle pc_en=1, next_pc=RESET_VECTOR; remaining BOOT_CYCLES-1 cycles pc_en=0; fetch_valid=0; all redirect/stall inputs ignored; then -> RUN.
REQ-020 Redirect priority in RUN/WAIT SHALL be trap > jump > branch_taken; lower-priority requests in the same cycle are dropped.
REQ-021 Redirect: pc_en=1, next_pc=selected target, flush=1, fetch_valid=0, -> REDIRECT; redirect overrides stall and imem_ready=0.
REQ-022 REDIRECT: exactly one bubble cycle, pc_en=0, fetch_valid=0, flush=0, inputs ignored, -> RUN.
REQ-023 RUN, no redirect, stall=1: pc_en=0, fetch_valid=0, stay RUN.
REQ-024 RUN, no redirect, stall=0, imem_ready=0: pc_en=0, fetch_valid=0, -> WAIT.
REQ-025 RUN/WAIT, no redirect, stall=0, imem_ready=1: pc_en=1, next_pc=pc_in+4, fetch_valid=1, -> RUN.
REQ-026 WAIT, stall=1 or imem_ready=0: pc_en=0, fetch_valid=0, stay WAIT.
REQ-027 Sequential increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no error flagged.
REQ-028 When pc_en=0, next_pc SHALL equal pc_in.

Reset
REQ-029 rst_n low SHALL immediately force state=BOOT, boot counter=0, pc_en=0, next_pc=RESET_VECTOR, fetch_valid=0, flush=0, misalign_err=0, independent of clk.
REQ-030 Reset asserted mid-WAIT or mid-REDIRECT SHALL abandon the operation; sequence restarts at BOOT on release.

Configuration
REQ-031 Macro PC_CTRL_MISALIGN_CHK_EN defined: jump/branch target with bits[1:0]!=0 SHALL redirect to TRAP_VECTOR with flush=1 and misalign_err=1 for that cycle.
REQ-032 Macro undefined: no check; target used as given; misalign_err tied 0.

Structure
REQ-033 Package pc_ctrl_pkg SHALL hold the state enum, PC_STEP=4, and the redirect-cause enum (NONE, TRAP, JUMP, BRANCH, MISALIGN).
REQ-034 Sub-module pc_redirect_sel SHALL implement the combinational priority select (inputs: trap, jump, branch and targets; outputs: redirect, target, cause); FSM and boot counter stay in pc_ctrl.

Verification
REQ-035 Reset release, RESET_VECTOR=0, BOOT_CYCLES=2, stall=0, imem_ready=1 -> pc_en=1/next_pc=0 cycle 1, pc_en=0 cycle 2, then next_pc 4, 8, 12 with fetch_valid=1.
REQ-036 RUN at pc_in=0x10, trap=1, jump=1 (0x40), branch_taken=1 (0x80) same cycle -> next_pc=0x100, flush=1 one cycle, one bubble, then next_pc=pc_in+4.
REQ-037 RUN, stall=1 for 3 cycles -> pc_en=0 for 3 cycles; imem_ready=0 for 2 cycles -> state=WAIT, pc_en=0, resume +4 on ready.
REQ-038 pc_in=0xFFFF_FFFC, no events -> next_pc=0x0000_0000, misalign_err=0.
REQ-039 With PC_CTRL_MISALIGN_CHK_EN, jump_target=0x42 -> next_pc=0x100, misalign_err=1; without the macro -> next_pc=0x42, misalign_err=0.
REQ-040 rst_n low mid-WAIT between clock edges -> outputs at reset values immediately, state=BOOT.
